// File: rtl/ht16k33_sequencer.sv
// ht16k33_sequencer: drives an I2C master to initialise an HT16K33 LED driver and
// to write four hex digits (with decimal points) to a 4-digit 7-segment backpack.
// Optional feature macro: SEVSEG_COLON_EN adds a 'colon' input mapped to display byte b4.
module ht16k33_sequencer #(
    parameter int         CLK_FREQ      = 27_000_000,
    parameter int         BOOT_DELAY_US = 1000,
    parameter logic [6:0] SLAVE_ADDR    = 7'h70,
    parameter logic [3:0] BRIGHTNESS    = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
`ifdef SEVSEG_COLON_EN
    input  logic        colon,
`endif
    input  logic        update,
    output logic        busy,
    output logic        enable,
    output logic        transaction,
    output logic        rd_wr,
    output logic [7:0]  i2c_atomic,
    output logic [6:0]  slave_addr,
    output logic [7:0]  data_out,
    input  logic        ready
);

    // I2C master atom codes
    localparam logic [7:0] MY_I2C_IDLE  = 8'h00;
    localparam logic [7:0] MY_I2C_START = 8'h01;
    localparam logic [7:0] MY_I2C_WRITE = 8'h02;
    localparam logic [7:0] MY_I2C_STOP  = 8'h03;

    localparam logic [31:0] BOOT_CYCLES = 32'(CLK_FREQ / 1_000_000 * BOOT_DELAY_US);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_NEXT,
        ST_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic        frame_q, frame_d;
    logic [31:0] boot_cnt_q, boot_cnt_d;
    logic        pending_q, pending_d;
    logic [15:0] sh_digits_q, sh_digits_d;
    logic [3:0]  sh_dp_q, sh_dp_d;
    logic        sh_colon_q, sh_colon_d;

    logic [7:0]  cur_atom;
    logic [7:0]  cur_data;
    logic [7:0]  colon_byte;
    logic [3:0]  last_step;

    // hex nibble to active-high segments {dp,g,f,e,d,c,b,a}
    function automatic logic [7:0] seg(input logic [3:0] h, input logic p);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return {p, s};
    endfunction

`ifdef SEVSEG_COLON_EN
    assign sh_colon_d = (state_q == ST_IDLE && (update || pending_q)) ? colon : sh_colon_q;
    assign colon_byte = sh_colon_q ? 8'h02 : 8'h00;
`else
    assign sh_colon_d = 1'b0;
    assign colon_byte = 8'h00;
`endif

    assign last_step = frame_q ? 4'd12 : 4'd8;

    // Atom and byte for the current step of the active program (init or frame).
    // Frame bytes: b0 carries the low digit nibble, b8 the high nibble.
    always_comb begin
        cur_atom = MY_I2C_STOP;
        cur_data = 8'h00;
        if (!frame_q) begin
            case (step_q)
                4'd0, 4'd3, 4'd6: cur_atom = MY_I2C_START;
                4'd1: begin cur_atom = MY_I2C_WRITE; cur_data = 8'h21; end
                4'd4: begin cur_atom = MY_I2C_WRITE; cur_data = 8'h81; end
                4'd7: begin cur_atom = MY_I2C_WRITE; cur_data = {4'hE, BRIGHTNESS}; end
                default: cur_atom = MY_I2C_STOP;
            endcase
        end else begin
            if (step_q == 4'd0) begin
                cur_atom = MY_I2C_START;
            end else if (step_q == 4'd12) begin
                cur_atom = MY_I2C_STOP;
            end else begin
                cur_atom = MY_I2C_WRITE;
                case (step_q)
                    4'd2:    cur_data = seg(sh_digits_q[3:0],   sh_dp_q[0]);
                    4'd4:    cur_data = seg(sh_digits_q[7:4],   sh_dp_q[1]);
                    4'd6:    cur_data = colon_byte;
                    4'd8:    cur_data = seg(sh_digits_q[11:8],  sh_dp_q[2]);
                    4'd10:   cur_data = seg(sh_digits_q[15:12], sh_dp_q[3]);
                    default: cur_data = 8'h00;
                endcase
            end
        end
    end

    // Next-state logic and the one-cycle command strobe
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        frame_d     = frame_q;
        boot_cnt_d  = boot_cnt_q;
        pending_d   = pending_q | update;
        sh_digits_d = sh_digits_q;
        sh_dp_d     = sh_dp_q;
        i2c_atomic  = MY_I2C_IDLE;
        data_out    = 8'h00;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q + 32'd1 >= BOOT_CYCLES) begin
                    boot_cnt_d = '0;
                    step_d     = '0;
                    frame_d    = 1'b0;
                    state_d    = ST_ISSUE;
                end else begin
                    boot_cnt_d = boot_cnt_q + 32'd1;
                end
            end
            ST_ISSUE: begin
                if (ready) begin
                    i2c_atomic = cur_atom;
                    data_out   = cur_data;
                    state_d    = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: if (!ready) state_d = ST_WAIT_HI;
            ST_WAIT_HI: if (ready)  state_d = ST_NEXT;
            ST_NEXT: begin
                if (step_q == last_step) begin
                    step_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_IDLE: begin
                if (update || pending_q) begin
                    sh_digits_d = digits;
                    sh_dp_d     = dp;
                    pending_d   = 1'b0;
                    frame_d     = 1'b1;
                    step_d      = '0;
                    state_d     = ST_ISSUE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State and shadow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            step_q      <= '0;
            frame_q     <= 1'b0;
            boot_cnt_q  <= '0;
            pending_q   <= 1'b0;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_colon_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            frame_q     <= frame_d;
            boot_cnt_q  <= boot_cnt_d;
            pending_q   <= pending_d;
            sh_digits_q <= sh_digits_d;
            sh_dp_q     <= sh_dp_d;
            sh_colon_q  <= sh_colon_d;
        end
    end

    assign transaction = (state_q != ST_BOOT) && (state_q != ST_IDLE) && (cur_atom != MY_I2C_STOP);
    assign busy        = !(state_q == ST_IDLE && !pending_q);
    assign enable      = !reset;
    assign rd_wr       = 1'b0;
    assign slave_addr  = SLAVE_ADDR;

endmodule
